// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Defaults shared by the oversample generator, transmitter and receiver.
  localparam int UART_OSR    = 16;
  localparam int UART_DATA_W = 8;

  // Receiver frame states. PARITY is only entered when parity support is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset value.
// Latency: 2 i_clk cycles from input change to o_q.
// Backpressure: none; free-running level path.
module uart_sync #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_nrst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // Two-stage capture of the asynchronous level; both stages reset to the idle value.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      meta <= RST_VAL;
      o_q  <= RST_VAL;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data/stop recovery, optional parity when UART_RX_PARITY_EN is defined.
// Latency: 2-cycle input sync, then o_valid/o_frame_err one i_clk after the mid-stop-bit tick.
// Backpressure: none; o_valid is a single-cycle strobe with no ready, the consumer must take it.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int OSR    = UART_OSR
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_tick,
  input  logic              i_rx,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic              o_parity_err,
`endif
  output logic              o_busy
);

  localparam int TICK_W = $clog2(OSR);
  localparam int BIT_W  = $clog2(DATA_W) + 1;

  // Start bit is confirmed half a bit after the edge; every later sample is one full bit on.
  localparam logic [TICK_W-1:0] MID_START = TICK_W'(OSR / 2 - 1);
  localparam logic [TICK_W-1:0] MID_BIT   = TICK_W'(OSR - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

  logic                rx_s;
  uart_rx_state_t      state, state_nxt;
  logic [TICK_W-1:0]   tick_cnt, tick_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic                load_data;
  logic                valid_nxt;
  logic                ferr_nxt;
`ifdef UART_RX_PARITY_EN
  logic                par_bit, par_nxt;
  logic                perr_nxt;
`endif

  uart_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_d    (i_rx),
    .o_q    (rx_s)
  );

  // Frame sequencing: every decision and counter step is qualified by the oversample tick.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    load_data = 1'b0;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
    perr_nxt  = 1'b0;
`endif
    if (i_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          if (tick_cnt == MID_START) begin
            tick_nxt = '0;
            if (!rx_s) begin
              state_nxt = DATA;
              bit_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == MID_BIT) begin
            tick_nxt  = '0;
            shreg_nxt = {rx_s, shreg[DATA_W-1:1]};
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              bit_nxt = bit_cnt + 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == MID_BIT) begin
            tick_nxt  = '0;
            par_nxt   = rx_s;
            state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick_cnt == MID_BIT) begin
            tick_nxt = '0;
            if (rx_s) begin
              state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
              if ((^shreg) ^ par_bit ^ PARITY_ODD) begin
                perr_nxt = 1'b1;
              end else begin
                load_data = 1'b1;
                valid_nxt = 1'b1;
              end
`else
              load_data = 1'b1;
              valid_nxt = 1'b1;
`endif
            end else begin
              // Stop bit low: report once, then wait for the line to go idle.
              ferr_nxt  = 1'b1;
              state_nxt = BREAK;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          tick_nxt  = '0;
        end
      endcase
    end
  end

  // State, counters and shift register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_nxt;
`endif
    end
  end

  // Registered outputs: data holds the last good word, strobes last one cycle.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      if (load_data) begin
        o_data <= shreg;
      end
      o_valid      <= valid_nxt;
      o_frame_err  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= perr_nxt;
`endif
    end
  end

  assign o_busy = (state != IDLE);

endmodule
